// File: rtl/store_unit_pkg.sv
// rtl/store_unit_pkg.sv - shared store size encodings, FSM states and lane helpers
// Purpose: types and helpers imported by store_lane_gen and store_unit.
// Ports: none (package).
package store_unit_pkg;

    // Store size encodings as driven on st_sel by the control decoder.
    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_RSV = 2'b11
    } st_sel_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BEAT0 = 2'b01,
        S_BEAT1 = 2'b10
    } state_e;

    // Right-justified byte mask for a store size, before shifting into lanes.
    function automatic logic [3:0] size_lanes(input logic [1:0] sel);
        case (sel)
            ST_SW:   size_lanes = 4'b1111;
            ST_SH:   size_lanes = 4'b0011;
            ST_SB:   size_lanes = 4'b0001;
            default: size_lanes = 4'b0000;
        endcase
    endfunction

    // Register data with bits above the store size forced to zero.
    function automatic logic [31:0] size_data(input logic [1:0] sel, input logic [31:0] data);
        case (sel)
            ST_SW:   size_data = data;
            ST_SH:   size_data = {16'h0000, data[15:0]};
            ST_SB:   size_data = {24'h000000, data[7:0]};
            default: size_data = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - combinational byte-lane alignment for one store request
// Purpose: maps address/data/size onto up to two word-aligned write beats.
// Ports:
//   addr, data, sel   in  request byte address, right-justified data, size
//   addr0, addr1      out word addresses of beat0 and beat1 (beat1 wraps mod 2^32)
//   wdata0, wdata1    out lane-aligned data per beat, disabled lanes zero
//   we0, we1          out per-byte write enables per beat
//   split             out request touches the following word
//   bad_sel           out reserved size encoding
module store_lane_gen
    import store_unit_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [1:0]  sel,
    output logic [31:0] addr0,
    output logic [31:0] addr1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [3:0]  we0,
    output logic [3:0]  we1,
    output logic        split,
    output logic        bad_sel
);

    logic [63:0] shifted;
    logic [7:0]  mask8;

    always_comb begin
        // Shifting across a 64-bit window lets a word-crossing store spill
        // naturally into the upper half, which becomes beat1.
        shifted = {32'h0000_0000, size_data(sel, data)} << {addr[1:0], 3'b000};
        mask8   = {4'b0000, size_lanes(sel)} << addr[1:0];
        addr0   = {addr[31:2], 2'b00};
        addr1   = addr0 + 32'd4;
        wdata0  = shifted[31:0];
        wdata1  = shifted[63:32];
        we0     = mask8[3:0];
        we1     = mask8[7:4];
        split   = (mask8[7:4] != 4'b0000);
        bad_sel = (sel == ST_RSV);
    end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - store request to byte-enabled word write beats
// Purpose: accepts a store (valid/ready), issues one or two registered write
//   beats (req/ack) with per-byte enables, pulses st_done or st_err.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   st_valid, st_ready            request handshake (ready only in IDLE)
//   st_addr, st_data, st_sel      request byte address, data, size
//   st_done, st_err               one-cycle completion / rejection pulses
//   mem_req, mem_ack              write beat handshake
//   mem_addr, mem_wdata, mem_we   registered word address, lane data, byte enables
module store_unit
    import store_unit_pkg::*;
#(
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_sel,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic        mem_ack
);

    state_e state, state_next;

    logic [31:0] lg_addr0, lg_addr1, lg_wdata0, lg_wdata1;
    logic [3:0]  lg_we0, lg_we1;
    logic        lg_split, lg_bad_sel;

    logic [31:0] b1_addr, b1_wdata;
    logic [3:0]  b1_we;
    logic        split_q;

    logic accept, illegal, start, final_ack;

    store_lane_gen u_lane_gen (
        .addr    (st_addr),
        .data    (st_data),
        .sel     (st_sel),
        .addr0   (lg_addr0),
        .addr1   (lg_addr1),
        .wdata0  (lg_wdata0),
        .wdata1  (lg_wdata1),
        .we0     (lg_we0),
        .we1     (lg_we1),
        .split   (lg_split),
        .bad_sel (lg_bad_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        final_ack  = 1'b0;
        accept     = st_valid && st_ready;
        // A word-crossing store is rejected outright when splitting is disabled.
        illegal    = lg_bad_sel || (!MISALIGN_SPLIT && lg_split);
        start      = accept && !illegal;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (mem_ack) begin
                    state_next = split_q ? S_BEAT1 : S_IDLE;
                    final_ack  = !split_q;
                end
            end
            S_BEAT1: begin
                if (mem_ack) begin
                    state_next = S_IDLE;
                    final_ack  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        st_ready = (state == S_IDLE);
        mem_req  = (state != S_IDLE);
    end

    // Beat registers: loaded with beat0 on accept, swapped to the latched beat1
    // on the beat0 ack so mem_req stays high across the split, cleared at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            mem_we    <= 4'b0000;
            b1_addr   <= 32'h0000_0000;
            b1_wdata  <= 32'h0000_0000;
            b1_we     <= 4'b0000;
            split_q   <= 1'b0;
        end else begin
            st_done <= final_ack;
            st_err  <= accept && illegal;
            if (start) begin
                mem_addr  <= lg_addr0;
                mem_wdata <= lg_wdata0;
                mem_we    <= lg_we0;
                b1_addr   <= lg_addr1;
                b1_wdata  <= lg_wdata1;
                b1_we     <= lg_we1;
                split_q   <= lg_split;
            end else if (state == S_BEAT0 && mem_ack && split_q) begin
                mem_addr  <= b1_addr;
                mem_wdata <= b1_wdata;
                mem_we    <= b1_we;
            end else if (final_ack) begin
                mem_addr  <= 32'h0000_0000;
                mem_wdata <= 32'h0000_0000;
                mem_we    <= 4'b0000;
                split_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed scoreboard bench for store_unit
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_sel = '0;
    logic        mem_ack = 1'b0;
    logic        st_ready, st_done, st_err, mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;

    logic        st_valid_ns = 1'b0;
    logic        mem_ack_ns = 1'b0;
    logic        st_ready_ns, st_done_ns, st_err_ns, mem_req_ns;
    logic [31:0] mem_addr_ns, mem_wdata_ns;
    logic [3:0]  mem_we_ns;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
    } beat_t;

    beat_t sb_q[$];

    always #5 clk = ~clk;

    store_unit #(.MISALIGN_SPLIT(1'b1)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_sel(st_sel),
        .st_done(st_done), .st_err(st_err), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ack(mem_ack)
    );

    store_unit #(.MISALIGN_SPLIT(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .st_valid(st_valid_ns), .st_ready(st_ready_ns),
        .st_addr(st_addr), .st_data(st_data), .st_sel(st_sel),
        .st_done(st_done_ns), .st_err(st_err_ns), .mem_req(mem_req_ns),
        .mem_addr(mem_addr_ns), .mem_wdata(mem_wdata_ns), .mem_we(mem_we_ns),
        .mem_ack(mem_ack_ns)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: place each store byte individually at address offset+i.
    task automatic push_model(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sel);
        beat_t b0, b1;
        int n, p;
        n = (sel == 2'b00) ? 4 : (sel == 2'b01) ? 2 : 1;
        b0 = '0;
        b1 = '0;
        b0.a = {addr[31:2], 2'b00};
        b1.a = b0.a + 32'd4;
        for (int i = 0; i < n; i++) begin
            p = int'(addr[1:0]) + i;
            if (p < 4) begin
                b0.d[8*p +: 8] = data[8*i +: 8];
                b0.w[p] = 1'b1;
            end else begin
                b1.d[8*(p-4) +: 8] = data[8*i +: 8];
                b1.w[p-4] = 1'b1;
            end
        end
        sb_q.push_back(b0);
        if (b1.w != 4'b0000) sb_q.push_back(b1);
    endtask

    // Called at a negedge; returns at the negedge of the st_done cycle so the
    // next call exercises acceptance in the same cycle as st_done.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] sel);
        beat_t exp;
        int nb;
        push_model(addr, data, sel);
        nb = sb_q.size();
        chk({tag, "_ready_in"}, {31'b0, st_ready}, 32'd1);
        st_valid = 1'b1;
        st_addr  = addr;
        st_data  = data;
        st_sel   = sel;
        @(negedge clk);
        st_valid = 1'b0;
        st_addr  = 32'h5555_5555;
        for (int b = 0; b < nb; b++) begin
            exp = sb_q.pop_front();
            chk({tag, "_req"},   {31'b0, mem_req}, 32'd1);
            chk({tag, "_addr"},  mem_addr, exp.a);
            chk({tag, "_wdata"}, mem_wdata, exp.d);
            chk({tag, "_we"},    {28'b0, mem_we}, {28'b0, exp.w});
            chk({tag, "_busy"},  {31'b0, st_ready}, 32'd0);
            chk({tag, "_nodone"}, {31'b0, st_done}, 32'd0);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        chk({tag, "_done"},   {31'b0, st_done}, 32'd1);
        chk({tag, "_noerr"},  {31'b0, st_err}, 32'd0);
        chk({tag, "_reqoff"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_ready"},  {31'b0, st_ready}, 32'd1);
    endtask

    initial begin
        beat_t exp;

        // Reset state
        @(negedge clk);
        chk("rst_req",   {31'b0, mem_req}, 32'd0);
        chk("rst_done",  {31'b0, st_done}, 32'd0);
        chk("rst_err",   {31'b0, st_err}, 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_we",    {28'b0, mem_we}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, st_ready}, 32'd1);

        // Aligned, sub-word and split stores, back to back
        do_store("sw100",  32'h0000_0100, 32'hDEAD_BEEF, 2'b00);
        do_store("sb103",  32'h0000_0103, 32'hFFFF_FFAB, 2'b10);
        do_store("sh203",  32'h0000_0203, 32'h0000_1234, 2'b01);
        do_store("swwrap", 32'hFFFF_FFFE, 32'h1122_3344, 2'b00);
        do_store("sh102",  32'h0000_0102, 32'hABCD_5678, 2'b01);
        do_store("sb301",  32'h0000_0301, 32'h1234_56C3, 2'b10);
        @(negedge clk);
        chk("done_pulse", {31'b0, st_done}, 32'd0);

        // Stall with st_valid held high, then reset mid-request
        push_model(32'h0000_0300, 32'hCAFE_F00D, 2'b00);
        st_valid = 1'b1;
        st_addr  = 32'h0000_0300;
        st_data  = 32'hCAFE_F00D;
        st_sel   = 2'b00;
        @(negedge clk);
        st_addr  = 32'h0000_0777;
        st_data  = 32'h0BAD_0BAD;
        exp = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk("stall_req",   {31'b0, mem_req}, 32'd1);
            chk("stall_addr",  mem_addr, exp.a);
            chk("stall_wdata", mem_wdata, exp.d);
            chk("stall_we",    {28'b0, mem_we}, {28'b0, exp.w});
            chk("stall_ready", {31'b0, st_ready}, 32'd0);
            chk("stall_done",  {31'b0, st_done}, 32'd0);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_req",  {31'b0, mem_req}, 32'd0);
        chk("abort_done", {31'b0, st_done}, 32'd0);
        chk("abort_we",   {28'b0, mem_we}, 32'd0);
        st_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_ready", {31'b0, st_ready}, 32'd1);
        chk("post_req",   {31'b0, mem_req}, 32'd0);
        chk("post_done",  {31'b0, st_done}, 32'd0);

        // Reserved size
        st_valid = 1'b1;
        st_addr  = 32'h0000_0400;
        st_sel   = 2'b11;
        @(negedge clk);
        st_valid = 1'b0;
        chk("rsv_err",   {31'b0, st_err}, 32'd1);
        chk("rsv_req",   {31'b0, mem_req}, 32'd0);
        chk("rsv_done",  {31'b0, st_done}, 32'd0);
        chk("rsv_ready", {31'b0, st_ready}, 32'd1);
        @(negedge clk);
        chk("rsv_errpulse", {31'b0, st_err}, 32'd0);
        chk("rsv_req2",     {31'b0, mem_req}, 32'd0);

        // Word-crossing store with splitting disabled
        st_valid_ns = 1'b1;
        st_addr     = 32'h0000_0101;
        st_data     = 32'h8765_4321;
        st_sel      = 2'b00;
        @(negedge clk);
        st_valid_ns = 1'b0;
        chk("ns_err",   {31'b0, st_err_ns}, 32'd1);
        chk("ns_req",   {31'b0, mem_req_ns}, 32'd0);
        chk("ns_done",  {31'b0, st_done_ns}, 32'd0);
        chk("ns_ready", {31'b0, st_ready_ns}, 32'd1);
        @(negedge clk);
        chk("ns_errpulse", {31'b0, st_err_ns}, 32'd0);
        chk("ns_req2",     {31'b0, mem_req_ns}, 32'd0);
        chk("sb_empty",    sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
